wb_flash_prefetch: RTL and testbench

Wishbone classic read-ahead buffer between the SD emulation core's Wishbone master and the SPI flash controller's Wishbone slave. It holds one aligned line of 32-bit words with per-word valid bits. On a read miss it refills sequentially from the requested word, so the sequential sector reads issued by the SD core hit in the buffer and avoid a full SPI transaction per word. Writes pass straight through and invalidate the line.

---
 rtl/wb_prefetch_pkg.sv | 22 ++
 rtl/wb_prefetch_line.sv | 43 ++++
 rtl/wb_flash_prefetch.sv | 185 ++++++++++++++++++
 tb/tb_wb_flash_prefetch.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_prefetch_pkg.sv
// Shared constants for the Wishbone flash read-ahead buffer: FSM encoding,
// bus constants and line-field width helpers.
package wb_prefetch_pkg;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] SEL_ALL    = 4'hF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  function automatic int index_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int tag_width(input int depth, input int addr_w);
    return addr_w - $clog2(WORD_BYTES) - $clog2(depth);
  endfunction

endpackage

// File: rtl/wb_prefetch_line.sv
// One prefetch line: DEPTH x 32-bit words with per-word valid bits,
// one write port, an asynchronous read port and a clear-all input.
module wb_prefetch_line
  import wb_prefetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = index_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  output logic             rd_valid
);

  logic [31:0]      words [DEPTH];
  logic [DEPTH-1:0] valid;

  // NOTE: sequential state uses <= so every flop samples pre-edge values,
  // independent of the order the always blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= '0;
    end else begin
      if (clr)   valid         <= '0;
      if (wr_en) valid[wr_idx] <= 1'b1;
    end
  end

  // NOTE: the data array has no reset; a word is never read out unless its
  // valid bit is set, so resetting it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) words[wr_idx] <= wr_data;
  end

  assign rd_data  = words[rd_idx];
  assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/wb_flash_prefetch.sv
// Wishbone classic read-ahead buffer in front of the SPI flash controller:
// one aligned line refilled sequentially from the missed word; writes pass through.
module wb_flash_prefetch
  import wb_prefetch_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              wb_clk_i,
  input  logic              reset_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [ADDR_W-1:0] wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [3:0]        wbs_sel_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  output logic [3:0]        wbm_sel_o,
  input  logic [31:0]       wbm_dat_i,
  input  logic              wbm_ack_i,
  output logic              o_busy
);

  localparam int               IDX_W    = index_width(DEPTH);
  localparam int               TAG_W    = tag_width(DEPTH, ADDR_W);
  localparam int               OFF_W    = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [2:0]        state;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  ptr;
  logic [ADDR_W-1:0] w_adr;
  logic [31:0]       w_dat;
  logic [3:0]        w_sel;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic              req, rd_req, wr_req;
  logic              tag_eq, line_hit, beat_hit;
  logic              fill_serve, fill_wait, fill_abort;
  logic              line_clr, line_wr;
  logic [31:0]       line_data;
  logic              line_valid;
  logic              unused_adr_bits;

  assign req_tag         = wbs_adr_i[ADDR_W-1 -: TAG_W];
  assign req_idx         = wbs_adr_i[OFF_W +: IDX_W];
  assign unused_adr_bits = ^wbs_adr_i[OFF_W-1:0];

  // The SD core holds stb until it sees ack, so the ack cycle itself is masked.
  assign req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign rd_req = req & ~wbs_we_i;
  assign wr_req = req & wbs_we_i;

  assign tag_eq   = (req_tag == tag_q);
  assign line_hit = tag_eq & line_valid;
  assign beat_hit = wbm_ack_i & (ptr == req_idx);

  // While filling: serve valid or just-arriving words, wait for words still
  // ahead of the fill pointer, abort for anything else.
  assign fill_serve = rd_req & tag_eq & (line_valid | beat_hit);
  assign fill_wait  = rd_req & tag_eq & ~fill_serve & (req_idx >= ptr);
  assign fill_abort = req & ~fill_serve & ~fill_wait;

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    line_clr = 1'b0;
    line_wr  = 1'b0;
    case (state)
      ST_IDLE:  line_clr = rd_req & ~line_hit;
      ST_FILL:  line_wr  = wbm_ack_i & ~fill_abort;
      ST_WRITE: line_clr = wbm_ack_i & (w_adr[ADDR_W-1 -: TAG_W] == tag_q);
      default:  ;
    endcase
  end

  wb_prefetch_line #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_line (
    .clk      (wb_clk_i),
    .reset_n  (reset_n),
    .clr      (line_clr),
    .wr_en    (line_wr),
    .wr_idx   (ptr),
    .wr_data  (wbm_dat_i),
    .rd_idx   (req_idx),
    .rd_data  (line_data),
    .rd_valid (line_valid)
  );

  always_comb begin
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    wbm_sel_o = '0;
    case (state)
      ST_FILL, ST_DRAIN: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_adr_o = {tag_q, ptr, {OFF_W{1'b0}}};
        wbm_sel_o = SEL_ALL;
      end
      ST_WRITE: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_adr_o = w_adr;
        wbm_dat_o = w_dat;
        wbm_sel_o = w_sel;
      end
      default: ;
    endcase
  end

  assign o_busy = (state != ST_IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      tag_q     <= '0;
      ptr       <= '0;
      w_adr     <= '0;
      w_dat     <= '0;
      w_sel     <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_req) begin
            w_adr <= {wbs_adr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            w_dat <= wbs_dat_i;
            w_sel <= wbs_sel_i;
            state <= ST_WRITE;
          end else if (rd_req) begin
            if (line_hit) begin
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= line_data;
              state     <= ST_RESP;
            end else begin
              tag_q <= req_tag;
              ptr   <= req_idx;
              state <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (fill_serve) begin
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= line_valid ? line_data : wbm_dat_i;
          end
          // An abort that coincides with the in-flight ack needs no drain.
          if (fill_abort) begin
            state <= wbm_ack_i ? ST_IDLE : ST_DRAIN;
          end else if (wbm_ack_i) begin
            if (ptr == LAST_IDX) state <= ST_IDLE;
            else                 ptr   <= ptr + IDX_W'(1);
          end
        end
        ST_DRAIN: begin
          if (wbm_ack_i) state <= ST_IDLE;
        end
        ST_WRITE: begin
          if (wbm_ack_i) begin
            wbs_ack_o <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_flash_prefetch.sv
// Scoreboard bench for wb_flash_prefetch: the buffer must look transparent, so
// every slave read returns the current flash contents; master beats are logged.
module tb_wb_flash_prefetch;

  typedef struct {
    logic        wr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
  } beat_t;

  logic        clk;
  logic        reset_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  exp_t        exp_q[$];
  beat_t       beat_q[$];
  logic [31:0] flash_mem [logic [31:0]];
  int          fl_wait = 0;
  int          fl_lo   = 2;
  int          fl_hi   = 2;
  beat_t       fl_b;

  wb_flash_prefetch #(.DEPTH(8), .ADDR_W(32)) dut (
    .wb_clk_i  (clk),
    .reset_n   (reset_n),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack_o (wbs_ack_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .o_busy    (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not occur within bound", name);
  endtask

  function automatic logic [31:0] flash_rd(input logic [31:0] a);
    if (flash_mem.exists(a)) return flash_mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Flash controller model: acks after a random wait, updates its memory on writes.
  always @(negedge clk) begin
    if (!reset_n || !(wbm_cyc_o && wbm_stb_o)) begin
      wbm_ack_i = 1'b0;
      fl_wait   = $urandom_range(fl_hi, fl_lo);
    end else if (fl_wait == 0) begin
      fl_b.adr = wbm_adr_o;
      fl_b.we  = wbm_we_o;
      fl_b.dat = wbm_dat_o;
      fl_b.sel = wbm_sel_o;
      beat_q.push_back(fl_b);
      if (wbm_we_o) begin
        flash_mem[wbm_adr_o] = merge(flash_rd(wbm_adr_o), wbm_dat_o, wbm_sel_o);
        wbm_dat_i = $urandom;
      end else begin
        check("m_rd_sel", {28'd0, wbm_sel_o}, 32'hF);
        check("m_rd_align", {30'd0, wbm_adr_o[1:0]}, 32'd0);
        wbm_dat_i = flash_rd(wbm_adr_o);
      end
      wbm_ack_i = 1'b1;
      fl_wait   = $urandom_range(fl_hi, fl_lo);
    end else begin
      wbm_ack_i = 1'b0;
      fl_wait--;
    end
  end

  // Monitor: every slave ack consumes the oldest expected response.
  always @(posedge clk) begin
    #1;
    if (reset_n && wbs_ack_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexp_ack: got ack with dat %h, want no ack", wbs_dat_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (!e.wr) check("rd_data", wbs_dat_o, e.data);
      end
    end
  end

  task automatic do_read(input logic [31:0] a, output int lat, output logic stb1,
                         output logic cyc_ack, output int n0);
    exp_t e;
    n0 = beat_q.size();
    @(negedge clk);
    e.wr   = 1'b0;
    e.data = flash_rd(a);
    exp_q.push_back(e);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = a;
    lat = 0; stb1 = 1'b0; cyc_ack = 1'b0;
    for (int n = 1; n <= 500; n++) begin
      @(posedge clk); #1;
      if (n == 1) stb1 = wbm_stb_o;
      if (wbs_ack_o) begin
        lat     = n;
        cyc_ack = wbm_cyc_o;
        break;
      end
    end
    if (lat == 0) fail_now("rd_timeout");
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    bit   seen = 0;
    @(negedge clk);
    e.wr   = 1'b1;
    e.data = 32'd0;
    exp_q.push_back(e);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
    for (int n = 1; n <= 500; n++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail_now("wr_timeout");
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 500; n++) begin
      @(posedge clk); #1;
      if (!o_busy) return;
    end
    fail_now("idle_timeout");
  endtask

  task automatic poll_adr(input logic [31:0] a);
    for (int n = 0; n < 500; n++) begin
      @(posedge clk); #1;
      if (wbm_cyc_o && wbm_stb_o && wbm_adr_o == a) return;
    end
    fail_now("adr_timeout");
  endtask

  initial begin
    int   lat, n0, base;
    logic stb1, cyc_ack;

    reset_n   = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
    wbm_ack_i = 1'b0; wbm_dat_i = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_wbs_ack", {31'd0, wbs_ack_o}, 32'd0);
    check("rst_wbs_dat", wbs_dat_o, 32'd0);
    check("rst_wbm_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check("rst_wbm_stb", {31'd0, wbm_stb_o}, 32'd0);
    check("rst_wbm_we", {31'd0, wbm_we_o}, 32'd0);
    check("rst_wbm_adr", wbm_adr_o, 32'd0);
    check("rst_wbm_dat", wbm_dat_o, 32'd0);
    check("rst_wbm_sel", {28'd0, wbm_sel_o}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    #1 reset_n = 1'b1;

    // Cold read: master stb the cycle after the request, slave ack after the first beat.
    base = beat_q.size();
    do_read(32'h100, lat, stb1, cyc_ack, n0);
    check("cold_stb_next", {31'd0, stb1}, 32'd1);
    check("cold_beats_at_ack", beat_q.size() - n0, 32'd1);
    check("cold_first_adr", beat_q[$].adr, 32'h100);

    // Wait on a word the fill has not reached yet.
    poll_adr(32'h10C);
    do_read(32'h118, lat, stb1, cyc_ack, n0);
    check("wait_lat_gt1", {31'd0, lat > 1}, 32'd1);
    check("wait_last_beat", beat_q[$].adr, 32'h118);
    wait_idle();
    check("fill_beat_count", beat_q.size() - base, 32'd8);
    for (int i = 0; i < 8; i++)
      if (base + i < beat_q.size())
        check("fill_order", beat_q[base+i].adr, 32'h100 + 32'(4*i));

    // Hit after fill.
    do_read(32'h104, lat, stb1, cyc_ack, n0);
    check("hit_lat", lat, 32'd1);
    check("hit_no_cyc", {31'd0, cyc_ack}, 32'd0);
    check("hit_no_beats", beat_q.size() - n0, 32'd0);

    // Abort: in-flight beat completes and is dropped, then refill from the new address.
    do_read(32'h200, lat, stb1, cyc_ack, n0);
    poll_adr(32'h208);
    base = beat_q.size();
    do_read(32'h140, lat, stb1, cyc_ack, n0);
    if (beat_q.size() >= base + 2) begin
      check("abort_drain_adr", beat_q[base].adr, 32'h208);
      check("abort_restart_adr", beat_q[base+1].adr, 32'h140);
    end else begin
      fail_now("abort_beats");
    end
    wait_idle();

    // Write invalidates the line holding its tag.
    do_read(32'h100, lat, stb1, cyc_ack, n0);
    wait_idle();
    base = beat_q.size();
    do_write(32'h108, 32'hDEAD_BEEF, 4'b0011);
    check("wr_beat_count", beat_q.size() - base, 32'd1);
    check("wr_beat_we", {31'd0, beat_q[$].we}, 32'd1);
    check("wr_beat_adr", beat_q[$].adr, 32'h108);
    check("wr_beat_dat", beat_q[$].dat, 32'hDEAD_BEEF);
    check("wr_beat_sel", {28'd0, beat_q[$].sel}, 32'h3);
    do_read(32'h10C, lat, stb1, cyc_ack, n0);
    if (beat_q.size() > n0) check("inval_refetch", beat_q[n0].adr, 32'h10C);
    else fail_now("inval_refetch");
    do_read(32'h108, lat, stb1, cyc_ack, n0);
    wait_idle();

    // Reset for one cycle mid-fill drops the master cycle and the line.
    do_read(32'h300, lat, stb1, cyc_ack, n0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("rstmid_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check("rstmid_busy", {31'd0, o_busy}, 32'd0);
    #1 reset_n = 1'b1;
    do_read(32'h300, lat, stb1, cyc_ack, n0);
    if (beat_q.size() > n0) check("rstmid_miss", beat_q[n0].adr, 32'h300);
    else fail_now("rstmid_miss");
    wait_idle();

    // Random traffic over four neighbouring lines with random flash latency.
    fl_lo = 0;
    fl_hi = 3;
    for (int op = 0; op < 200; op++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      repeat ($urandom_range(2, 0)) @(negedge clk);
      a = 32'h1000 + 32'($urandom_range(31, 0)) * 4;
      if ($urandom_range(9, 0) < 2) begin
        d = $urandom;
        s = 4'($urandom_range(15, 1));
        do_write(a, d, s);
        check("rnd_wr_adr", beat_q[$].adr, a);
        check("rnd_wr_dat", beat_q[$].dat, d);
        check("rnd_wr_sel", {28'd0, beat_q[$].sel}, {28'd0, s});
      end else begin
        do_read(a, lat, stb1, cyc_ack, n0);
      end
    end
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
